// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, pipeline control word and hazard helpers for pipe_ctrl.
// Mult/div encodings are only decoded when PIPE_CTRL_MULDIV_EN is defined.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // TUSE_NONE exceeds every Tnew, so an unused source can never raise a hazard
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_PC  = 2'd0;
  localparam logic [1:0] TNEW_ALU = 2'd1;
  localparam logic [1:0] TNEW_LD  = 2'd2;

  // dest keeps the 5-bit ISA field; the top resizes it to RA_W on the ports
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_src;
    logic [4:0] dest;
    logic [1:0] tnew;
    logic       md_start;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [1:0] ext_op;
    logic [1:0] npc_sel;
    logic       is_branch;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       md_use;
  } dec_t;

  function automatic logic raw_hz(logic [4:0] src, logic [1:0] tuse,
                                  logic [4:0] dst, logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tnew > tuse);
  endfunction

  function automatic logic [1:0] tnew_age(logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/control bundle between the datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic [XLEN-1:0] instr_d;
  logic [1:0]      ext_op_d;
  logic [1:0]      npc_sel_d;
  logic            is_branch_d;
  logic            stall;
  logic [2:0]      alu_op_e;
  logic            alu_src_e;
  logic            mem_write_m;
  logic            reg_write_w;
  logic [1:0]      reg_src_w;
  logic [RA_W-1:0] wa_e;
  logic [RA_W-1:0] wa_m;
  logic [RA_W-1:0] wa_w;
  logic            md_start_e;
  logic            md_busy;

  modport master (
    output instr_d,
    input  ext_op_d, npc_sel_d, is_branch_d, stall, alu_op_e, alu_src_e,
           mem_write_m, reg_write_w, reg_src_w, wa_e, wa_m, wa_w,
           md_start_e, md_busy
  );

  modport slave (
    input  instr_d,
    output ext_op_d, npc_sel_d, is_branch_d, stall, alu_op_e, alu_src_e,
           mem_write_m, reg_write_w, reg_src_w, wa_e, wa_m, wa_w,
           md_start_e, md_busy
  );
endinterface

// File: rtl/pipe_ctrl_dec.sv
// Combinational instruction -> control word decoder for the D stage.
// MULT/DIV/MFHI/MFLO decode only under PIPE_CTRL_MULDIV_EN.
module pipe_ctrl_dec
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output dec_t            dec
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic       unused_shamt;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign fn = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    dec         = '0;
    dec.rs      = rs;
    dec.rt      = rt;
    dec.tuse_rs = TUSE_NONE;
    dec.tuse_rt = TUSE_NONE;
    case (op)
      OP_ORI, OP_LUI: begin
        dec.ext_op         = (op == OP_ORI) ? 2'b01 : 2'b10;
        dec.ctrl.alu_op    = 3'b010;
        dec.ctrl.alu_src   = 1'b1;
        dec.ctrl.reg_write = 1'b1;
        dec.ctrl.dest      = rt;
        dec.ctrl.tnew      = TNEW_ALU;
        dec.tuse_rs        = TUSE_E;
      end
      OP_LW: begin
        dec.ctrl.alu_src   = 1'b1;
        dec.ctrl.reg_write = 1'b1;
        dec.ctrl.reg_src   = 2'b01;
        dec.ctrl.dest      = rt;
        dec.ctrl.tnew      = TNEW_LD;
        dec.tuse_rs        = TUSE_E;
      end
      OP_SW: begin
        dec.ctrl.alu_src   = 1'b1;
        dec.ctrl.mem_write = 1'b1;
        dec.tuse_rs        = TUSE_E;
        dec.tuse_rt        = TUSE_M;
      end
      OP_J: begin
        dec.npc_sel   = 2'b10;
        dec.is_branch = 1'b1;
      end
      OP_JAL: begin
        dec.npc_sel        = 2'b10;
        dec.is_branch      = 1'b1;
        dec.ctrl.reg_write = 1'b1;
        dec.ctrl.reg_src   = 2'b10;
        dec.ctrl.dest      = 5'd31;
        dec.ctrl.tnew      = TNEW_PC;
      end
      OP_BEQ: begin
        dec.npc_sel   = 2'b01;
        dec.is_branch = 1'b1;
        dec.tuse_rs   = TUSE_D;
        dec.tuse_rt   = TUSE_D;
      end
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            dec.ctrl.alu_op    = (fn == FN_SUBU) ? 3'b001 : 3'b000;
            dec.ctrl.reg_write = 1'b1;
            dec.ctrl.dest      = rd;
            dec.ctrl.tnew      = TNEW_ALU;
            dec.tuse_rs        = TUSE_E;
            dec.tuse_rt        = TUSE_E;
          end
          FN_JALR: begin
            dec.npc_sel        = 2'b11;
            dec.is_branch      = 1'b1;
            dec.ctrl.reg_write = 1'b1;
            dec.ctrl.reg_src   = 2'b10;
            dec.ctrl.dest      = rd;
            dec.ctrl.tnew      = TNEW_PC;
            dec.tuse_rs        = TUSE_D;
          end
`ifdef PIPE_CTRL_MULDIV_EN
          FN_MULT, FN_DIV: begin
            dec.ctrl.md_start = 1'b1;
            dec.md_use        = 1'b1;
            dec.tuse_rs       = TUSE_E;
            dec.tuse_rt       = TUSE_E;
          end
          FN_MFHI, FN_MFLO: begin
            dec.ctrl.reg_write = 1'b1;
            dec.ctrl.reg_src   = 2'b11;
            dec.ctrl.dest      = rd;
            dec.ctrl.tnew      = TNEW_ALU;
            dec.md_use         = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
    // writes to $0 are dropped so they never look like forwarding sources
    if (dec.ctrl.dest == 5'd0) dec.ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: D decode, RAW stall detection, E/M/W control-word registers.
// Define PIPE_CTRL_MULDIV_EN to add the mult/div busy counter and its interlock.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int MD_LAT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  pc
);

  dec_t  dec;
  ctrl_t e_d, e_q, m_d, m_q, w_d, w_q;
  logic  stall, raw_stall, md_stall;
  logic  md_start_e, md_busy;
  logic  unused_w;

  pipe_ctrl_dec #(.XLEN(XLEN)) u_dec (
    .instr (pc.instr_d),
    .dec   (dec)
  );

  assign raw_stall = raw_hz(dec.rs, dec.tuse_rs, e_q.dest, e_q.tnew)
                   | raw_hz(dec.rt, dec.tuse_rt, e_q.dest, e_q.tnew)
                   | raw_hz(dec.rs, dec.tuse_rs, m_q.dest, m_q.tnew)
                   | raw_hz(dec.rt, dec.tuse_rt, m_q.dest, m_q.tnew);

`ifdef PIPE_CTRL_MULDIV_EN
  logic [3:0] md_cnt_d, md_cnt_q;

  assign md_start_e = e_q.md_start;
  assign md_busy    = (md_cnt_q != 4'd0);
  // start cycle counts too, so an MF*/MULT right behind a MULT waits MD_LAT+1
  assign md_stall   = dec.md_use & (md_busy | md_start_e);

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_e)   md_cnt_d = 4'(MD_LAT);
    else if (md_busy) md_cnt_d = md_cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) md_cnt_q <= 4'd0;
    else        md_cnt_q <= md_cnt_d;
  end
`else
  localparam int md_lat_unused = MD_LAT;
  logic unused_md;

  assign md_start_e = 1'b0;
  assign md_busy    = 1'b0;
  assign md_stall   = 1'b0;
  assign unused_md  = dec.md_use;
`endif

  assign stall = raw_stall | md_stall;

  always_comb begin
    e_d      = stall ? CTRL_BUBBLE : dec.ctrl;
    m_d      = e_q;
    m_d.tnew = tnew_age(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = tnew_age(m_q.tnew);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= CTRL_BUBBLE;
      m_q <= CTRL_BUBBLE;
      w_q <= CTRL_BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign unused_w = ^{w_q.alu_op, w_q.alu_src, w_q.mem_write, w_q.tnew, w_q.md_start};

  assign pc.ext_op_d    = dec.ext_op;
  assign pc.npc_sel_d   = dec.npc_sel;
  assign pc.is_branch_d = dec.is_branch;
  assign pc.stall       = stall;
  assign pc.alu_op_e    = e_q.alu_op;
  assign pc.alu_src_e   = e_q.alu_src;
  assign pc.mem_write_m = m_q.mem_write;
  assign pc.reg_write_w = w_q.reg_write;
  assign pc.reg_src_w   = w_q.reg_src;
  assign pc.wa_e        = RA_W'(e_q.dest);
  assign pc.wa_m        = RA_W'(m_q.dest);
  assign pc.wa_w        = RA_W'(w_q.dest);
  assign pc.md_start_e  = md_start_e;
  assign pc.md_busy     = md_busy;

endmodule
